// File: rtl/mem_port_sched.sv
// mem_port_sched -- schedules the single memory unit port between the load
// buffers (ld_1..ld_3, tags 6..8) and ROB store commits, drives the memory
// control encoding, and hands completed load results to the CDB arbiter.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   defined   : watchdog aborts LD_WAIT/ST_WAIT after TIMEOUT_CYCLES cycles
//               without mem_ready and sets a sticky o_timeout_err.
//   undefined : no watchdog, o_timeout_err tied 0, WAIT states wait forever.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_ld_req/tag/addr     load request (valid only for tags 6..8)
//   o_ld_grant            load accepted this cycle (Mealy, IDLE only)
//   i_st_req/addr/data    store commit request
//   o_st_grant            store accepted this cycle (Mealy, IDLE only)
//   i_mem_ready/rdata     memory completion pulse and load data
//   o_mem_control         01=load, 00=store, 11=idle (registered)
//   o_mem_address/data    registered address/data to memory
//   o_cdb_req/write_id/value  CDB request for a finished load
//   i_cdb_grant           CDB arbiter grant
//   o_remove/remove_tag   one-cycle pulse freeing the load entry
//   o_busy                state != IDLE
//   o_timeout_err         sticky watchdog error
//
// state    | meaning
// IDLE     | port free, arbitrate between load and store
// LD_WAIT  | load issued, waiting for mem_ready
// ST_WAIT  | store issued, waiting for mem_ready
// CDB_WAIT | load data held, requesting CDB until granted

module mem_port_sched #(
  parameter int DATA_W        = 64,
  parameter int ST_STREAK_MAX = 4
`ifdef MEM_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ld_req,
  input  logic [3:0]        i_ld_tag,
  input  logic [DATA_W-1:0] i_ld_addr,
  output logic              o_ld_grant,
  input  logic              i_st_req,
  input  logic [DATA_W-1:0] i_st_addr,
  input  logic [DATA_W-1:0] i_st_data,
  output logic              o_st_grant,
  input  logic              i_mem_ready,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [1:0]        o_mem_control,
  output logic [DATA_W-1:0] o_mem_address,
  output logic [DATA_W-1:0] o_mem_data,
  output logic              o_cdb_req,
  output logic [3:0]        o_cdb_write_id,
  output logic [DATA_W-1:0] o_cdb_value,
  input  logic              i_cdb_grant,
  output logic              o_remove,
  output logic [3:0]        o_remove_tag,
  output logic              o_busy,
  output logic              o_timeout_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LD_WAIT  = 2'd1,
    ST_WAIT  = 2'd2,
    CDB_WAIT = 2'd3
  } state_t;

  localparam logic [1:0] CTL_LOAD  = 2'b01;
  localparam logic [1:0] CTL_STORE = 2'b00;
  localparam logic [1:0] CTL_IDLE  = 2'b11;

  localparam int STREAK_W = $clog2(ST_STREAK_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(ST_STREAK_MAX);

  state_t              r_state;
  state_t              w_next;
  logic [STREAK_W-1:0] r_streak;
  logic [1:0]          r_mem_control;
  logic [DATA_W-1:0]   r_mem_address;
  logic [DATA_W-1:0]   r_mem_data;
  logic [3:0]          r_tag;
  logic [DATA_W-1:0]   r_cdb_value;

  logic w_ld_valid;
  logic w_st_win;
  logic w_in_wait;
  logic w_to_hit;

  assign w_ld_valid = i_ld_req && (i_ld_tag >= 4'd6) && (i_ld_tag <= 4'd8);
  // A waiting load only yields to stores until the streak limit is hit.
  assign w_st_win   = i_st_req && (!w_ld_valid || (r_streak < STREAK_MAX));
  assign w_in_wait  = (r_state == LD_WAIT) || (r_state == ST_WAIT);

`ifdef MEM_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_timeout_err;

  // Down-counter loaded on grant; terminal count in a WAIT state without
  // mem_ready ends the access.
  assign w_to_hit = w_in_wait && (r_to_cnt == '0) && !i_mem_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (o_ld_grant || o_st_grant) begin
        r_to_cnt <= TO_LOAD;
      end else if (w_in_wait && (r_to_cnt != '0)) begin
        r_to_cnt <= r_to_cnt - 1'b1;
      end
      if (w_to_hit) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign o_timeout_err = r_timeout_err;
`else
  assign w_to_hit      = 1'b0;
  assign o_timeout_err = 1'b0;
`endif

  always_comb begin
    w_next     = r_state;
    o_ld_grant = 1'b0;
    o_st_grant = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_st_win) begin
          o_st_grant = 1'b1;
          w_next     = ST_WAIT;
        end else if (w_ld_valid) begin
          o_ld_grant = 1'b1;
          w_next     = LD_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_mem_ready || w_to_hit) begin
          w_next = IDLE;
        end
      end
      LD_WAIT: begin
        if (i_mem_ready) begin
          w_next = CDB_WAIT;
        end else if (w_to_hit) begin
          w_next = IDLE;
        end
      end
      CDB_WAIT: begin
        if (i_cdb_grant) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_streak      <= '0;
      r_mem_control <= CTL_IDLE;
      r_mem_address <= '0;
      r_mem_data    <= '0;
      r_tag         <= '0;
      r_cdb_value   <= '0;
    end else begin
      r_state <= w_next;
      if (o_st_grant) begin
        r_mem_control <= CTL_STORE;
        r_mem_address <= i_st_addr;
        r_mem_data    <= i_st_data;
        if (w_ld_valid) begin
          if (r_streak != STREAK_MAX) begin
            r_streak <= r_streak + 1'b1;
          end
        end else begin
          r_streak <= '0;
        end
      end else if (o_ld_grant) begin
        r_mem_control <= CTL_LOAD;
        r_mem_address <= i_ld_addr;
        r_mem_data    <= '0;
        r_tag         <= i_ld_tag;
        r_streak      <= '0;
      end else if (w_in_wait && (w_next != r_state)) begin
        r_mem_control <= CTL_IDLE;
      end
      if ((r_state == LD_WAIT) && i_mem_ready) begin
        r_cdb_value <= i_mem_rdata;
      end
    end
  end

  assign o_mem_control  = r_mem_control;
  assign o_mem_address  = r_mem_address;
  assign o_mem_data     = r_mem_data;
  assign o_busy         = (r_state != IDLE);
  assign o_cdb_req      = (r_state == CDB_WAIT);
  assign o_cdb_write_id = o_cdb_req ? r_tag : 4'd0;
  assign o_cdb_value    = r_cdb_value;
  assign o_remove       = o_cdb_req && i_cdb_grant;
  assign o_remove_tag   = o_remove ? r_tag : 4'd0;

endmodule
